// File: rtl/scroll_list_menu.sv
// Scrolling list selector: preloads entry names from a synchronous ROM, moves a cursor
// with wrap and hold-to-repeat, and renders the visible window of rows as ASCII text.
module scroll_list_menu #(
  parameter int N_ITEMS       = 16,
  parameter int VIS_ROWS      = 5,
  parameter int NAME_LEN      = 16,
  parameter int ROW_CHARS     = 32,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                               prog_clk,
  input  logic                               rst,
  input  logic [3:0]                         arrow_keys,
  output logic [$clog2(N_ITEMS)-1:0]         rd_id,
  input  logic [NAME_LEN*8-1:0]              rd_name,
  output logic [VIS_ROWS*ROW_CHARS*8-1:0]    rows,
  output logic [$clog2(N_ITEMS)-1:0]         cursor,
  output logic [$clog2(N_ITEMS)-1:0]         top,
  output logic                               loading,
  output logic                               sel_valid,
  output logic [$clog2(N_ITEMS)-1:0]         sel_id,
  output logic                               sel_auto
);

  localparam int ID_W    = $clog2(N_ITEMS);
  localparam int CNT_W   = ID_W + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [ID_W-1:0]       LAST_ID    = ID_W'(N_ITEMS - 1);
  localparam logic [CNT_W-1:0]      LOAD_END   = CNT_W'(N_ITEMS);
  localparam logic [RPT_W-1:0]      DELAY_C    = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]      PERIOD_C   = RPT_W'(REPEAT_PERIOD);
  localparam logic [7:0]            N_B        = 8'(N_ITEMS);
  localparam logic [7:0]            VIS_B      = 8'(VIS_ROWS);
  localparam logic [NAME_LEN*8-1:0] BLANK_NAME = {NAME_LEN{8'h20}};

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_HOLD} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_loadCnt;
  logic [RPT_W-1:0]      r_rptCnt;
  logic                  r_rptPast;
  logic [3:0]            r_prevKeys;
  logic [ID_W-1:0]       r_cursor;
  logic [ID_W-1:0]       r_top;
  logic [ID_W-1:0]       r_rdId;
  logic [ID_W-1:0]       r_selId;
  logic                  r_loading;
  logic                  r_selValid;
  logic                  r_selAuto;
  logic [NAME_LEN*8-1:0] r_names [N_ITEMS];

  logic            w_oneHot;
  logic            w_press;
  logic            w_vert;
  logic            w_rptStep;
  logic [RPT_W-1:0] w_rptLimit;
  logic [ID_W-1:0] w_nextCur;
  logic [ID_W-1:0] w_nextTop;

  // Next cursor assumes UP when bit 3 is set, otherwise DOWN; only used for vertical keys.
  always_comb begin
    w_oneHot   = $onehot(arrow_keys);
    w_press    = w_oneHot && (arrow_keys != r_prevKeys);
    w_vert     = arrow_keys[3] | arrow_keys[2];
    w_rptLimit = r_rptPast ? PERIOD_C : DELAY_C;
    w_rptStep  = (r_rptCnt + RPT_W'(1)) == w_rptLimit;
    if (arrow_keys[3]) begin
      w_nextCur = (r_cursor == '0) ? LAST_ID : r_cursor - ID_W'(1);
    end else begin
      w_nextCur = (r_cursor == LAST_ID) ? '0 : r_cursor + ID_W'(1);
    end
    w_nextTop = r_top;
    if (w_nextCur < r_top) begin
      w_nextTop = w_nextCur;
    end else if (8'(w_nextCur) >= 8'(r_top) + VIS_B) begin
      w_nextTop = ID_W'(8'(w_nextCur) - VIS_B + 8'd1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_loadCnt  <= '0;
      r_rptCnt   <= '0;
      r_rptPast  <= 1'b0;
      r_prevKeys <= '0;
      r_cursor   <= '0;
      r_top      <= '0;
      r_rdId     <= '0;
      r_loading  <= 1'b1;
      r_selValid <= 1'b0;
      r_selId    <= '0;
      r_selAuto  <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        r_names[i] <= BLANK_NAME;
      end
    end else begin
      r_prevKeys <= arrow_keys;
      r_selValid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          // ROM data lags the address by one cycle, so entry c lands at the end of cycle c+1.
          if (r_loadCnt != '0) begin
            r_names[ID_W'(r_loadCnt - CNT_W'(1))] <= rd_name;
          end
          if (r_loadCnt == LOAD_END) begin
            r_loading <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_loadCnt <= r_loadCnt + CNT_W'(1);
            if (r_loadCnt + CNT_W'(1) < LOAD_END) begin
              r_rdId <= ID_W'(r_loadCnt + CNT_W'(1));
            end
          end
        end
        default: begin
          if (w_press) begin
            r_rptCnt  <= '0;
            r_rptPast <= 1'b0;
            if (w_vert) begin
              r_cursor <= w_nextCur;
              r_top    <= w_nextTop;
              r_state  <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
              if (arrow_keys[0] || (r_cursor != '0)) begin
                r_selValid <= 1'b1;
                r_selId    <= r_cursor;
                r_selAuto  <= arrow_keys[1];
              end
            end
          end else if (!w_oneHot) begin
            r_state <= S_IDLE;
          end else if (r_state == S_HOLD) begin
            // Same vertical key still held: first step after the delay, then every period.
            if (w_rptStep) begin
              r_cursor  <= w_nextCur;
              r_top     <= w_nextTop;
              r_rptCnt  <= '0;
              r_rptPast <= 1'b1;
            end else begin
              r_rptCnt <= r_rptCnt + RPT_W'(1);
            end
          end
        end
      endcase
    end
  end

  function automatic logic [ROW_CHARS*8-1:0] renderRow(input logic [7:0] entry,
                                                       input logic isCur,
                                                       input logic [NAME_LEN*8-1:0] name);
    logic [ROW_CHARS*8-1:0] row;
    row = {ROW_CHARS{8'h20}};
    if (entry < N_B) begin
      if (isCur) begin
        row[ROW_CHARS*8-1 -: 24] = 24'h3E3E3E;
      end
      row[(ROW_CHARS-5)*8 +: 8] = 8'h5B;
      row[(ROW_CHARS-6)*8 +: 8] = 8'h30 + entry / 8'd10;
      row[(ROW_CHARS-7)*8 +: 8] = 8'h30 + entry % 8'd10;
      row[(ROW_CHARS-8)*8 +: 8] = 8'h5D;
      row[(ROW_CHARS-10)*8-1 -: NAME_LEN*8] = name;
    end
    return row;
  endfunction

  for (genvar r = 0; r < VIS_ROWS; r++) begin : gRow
    logic [7:0]      w_entry;
    logic [ID_W-1:0] w_nameIdx;
    assign w_entry   = 8'(r_top) + 8'(r);
    assign w_nameIdx = (w_entry < N_B) ? ID_W'(w_entry) : '0;
    assign rows[(VIS_ROWS-1-r)*ROW_CHARS*8 +: ROW_CHARS*8] =
      renderRow(w_entry, w_entry == 8'(r_cursor), r_names[w_nameIdx]);
  end

  assign rd_id     = r_rdId;
  assign cursor    = r_cursor;
  assign top       = r_top;
  assign loading   = r_loading;
  assign sel_valid = r_selValid;
  assign sel_id    = r_selId;
  assign sel_auto  = r_selAuto;

endmodule

// File: tb/tb_scroll_list_menu.sv
// Bench for scroll_list_menu: a string-level menu model checked every cycle, plus
// directed key sequences with literal expectations, and a small 3-entry instance.
module tb_scroll_list_menu;

  localparam int N   = 16;
  localparam int VIS = 5;
  localparam int NL  = 16;
  localparam int RC  = 32;
  localparam int DLY = 50;
  localparam int PER = 10;

  localparam logic [3:0] K_UP    = 4'b1000;
  localparam logic [3:0] K_DOWN  = 4'b0100;
  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_RIGHT = 4'b0001;
  localparam logic [3:0] K_NONE  = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [3:0]          keys;
  logic [3:0]          rdId;
  logic [NL*8-1:0]     rdName;
  logic [VIS*RC*8-1:0] rows;
  logic [3:0]          cursor, top, selId;
  logic                loading, selValid, selAuto;

  logic [3:0]          keys3;
  logic [1:0]          rdId3, cursor3, top3, selId3;
  logic [NL*8-1:0]     rdName3;
  logic [VIS*RC*8-1:0] rows3;
  logic                loading3, selValid3, selAuto3;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  scroll_list_menu #(.N_ITEMS(N), .VIS_ROWS(VIS), .NAME_LEN(NL), .ROW_CHARS(RC),
                     .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .prog_clk(clk), .rst(rst), .arrow_keys(keys), .rd_id(rdId), .rd_name(rdName),
    .rows(rows), .cursor(cursor), .top(top), .loading(loading),
    .sel_valid(selValid), .sel_id(selId), .sel_auto(selAuto));

  scroll_list_menu #(.N_ITEMS(3), .VIS_ROWS(VIS), .NAME_LEN(NL), .ROW_CHARS(RC),
                     .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut3 (
    .prog_clk(clk), .rst(rst), .arrow_keys(keys3), .rd_id(rdId3), .rd_name(rdName3),
    .rows(rows3), .cursor(cursor3), .top(top3), .loading(loading3),
    .sel_valid(selValid3), .sel_id(selId3), .sel_auto(selAuto3));

  function automatic string songStr(int k);
    return $sformatf("SONG_%0d", k);
  endfunction

  function automatic logic [RC*8-1:0] padBytes(string s, int n);
    logic [RC*8-1:0] v;
    v = {RC{8'h20}};
    for (int i = 0; i < s.len() && i < n; i++) v[(n-1-i)*8 +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [NL*8-1:0] nameBits(int k);
    logic [RC*8-1:0] t;
    t = padBytes(songStr(k), NL);
    return t[NL*8-1:0];
  endfunction

  // Synchronous chart-info ROM: data follows the address by one cycle.
  always @(posedge clk) begin
    rdName  <= nameBits(int'(rdId));
    rdName3 <= nameBits(int'(rdId3));
  end

  function automatic logic [RC*8-1:0] getRow(int r);
    return rows[(VIS-1-r)*RC*8 +: RC*8];
  endfunction

  function automatic logic [RC*8-1:0] getRow3(int r);
    return rows3[(VIS-1-r)*RC*8 +: RC*8];
  endfunction

  task automatic checkOutput(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkRow(string nm, logic [RC*8-1:0] act, logic [RC*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got \"%s\" want \"%s\" at %0t", nm, act, exp, $time);
    end
  endtask

  // Menu model: cursor/top as integers, names as strings, holds measured in edges since press.
  int         mCursor, mTop, mLoadCyc, mHoldLen, mSelId;
  bit         mLoading, mHoldOk, mSelValid, mSelAuto;
  logic [3:0] mPrev;
  string      mNames [N];

  task automatic moveCursor(int d);
    mCursor = (mCursor + d + N) % N;
    if (mCursor < mTop) mTop = mCursor;
    else if (mCursor >= mTop + VIS) mTop = mCursor - VIS + 1;
  endtask

  task automatic modelStep(bit r, logic [3:0] k);
    if (r) begin
      mCursor = 0; mTop = 0; mLoading = 1; mLoadCyc = 0; mSelValid = 0;
      mSelId = 0; mSelAuto = 0; mHoldOk = 0; mHoldLen = 0; mPrev = K_NONE;
      for (int i = 0; i < N; i++) mNames[i] = "";
      return;
    end
    mSelValid = 0;
    if (mLoading) begin
      if (mLoadCyc >= 1) mNames[mLoadCyc-1] = songStr(mLoadCyc - 1);
      if (mLoadCyc == N) mLoading = 0;
      else mLoadCyc++;
      mHoldOk = 0;
    end else begin
      if ($onehot(k)) begin
        if (k != mPrev) begin
          mHoldOk = 1;
          mHoldLen = 0;
        end else begin
          mHoldLen++;
        end
      end else begin
        mHoldOk = 0;
      end
      if (mHoldOk) begin
        if (k[3] || k[2]) begin
          if (mHoldLen == 0 || (mHoldLen >= DLY && (mHoldLen - DLY) % PER == 0))
            moveCursor(k[3] ? -1 : 1);
        end else if (mHoldLen == 0 && (k[0] || mCursor != 0)) begin
          mSelValid = 1;
          mSelId = mCursor;
          mSelAuto = k[1];
        end
      end
    end
    mPrev = k;
  endtask

  function automatic logic [RC*8-1:0] expRow(int r);
    int e;
    string pre;
    e = mTop + r;
    if (e >= N) return padBytes("", RC);
    pre = (e == mCursor) ? ">>>" : "   ";
    return padBytes($sformatf("%s [%02d]  %s", pre, e, mNames[e]), RC);
  endfunction

  logic [3:0] sKeys;
  logic       sRst;
  bit         sSeen = 1'b0;
  always @(posedge clk) begin
    sKeys <= keys;
    sRst  <= rst;
    sSeen <= 1'b1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      if (sSeen) begin
        modelStep(sRst, sKeys);
        checkOutput("cursor", int'(cursor), mCursor);
        checkOutput("top", int'(top), mTop);
        checkOutput("loading", int'(loading), int'(mLoading));
        checkOutput("sel_valid", int'(selValid), int'(mSelValid));
        checkOutput("sel_id", int'(selId), mSelId);
        checkOutput("sel_auto", int'(selAuto), int'(mSelAuto));
        if (mLoading && mLoadCyc < N) checkOutput("rd_id", int'(rdId), mLoadCyc);
        for (int r = 0; r < VIS; r++)
          checkRow($sformatf("row%0d", r), getRow(r), expRow(r));
      end
    end
  end

  task automatic applyStimulus(logic [3:0] k, int n);
    keys = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic pressKey(logic [3:0] k, int times);
    for (int i = 0; i < times; i++) begin
      applyStimulus(k, 1);
      applyStimulus(K_NONE, 1);
    end
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    keys  = K_NONE;
    keys3 = K_NONE;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_cursor", int'(cursor), 0);
    checkOutput("rst_top", int'(top), 0);
    checkOutput("rst_loading", int'(loading), 1);
    checkOutput("rst_sel_valid", int'(selValid), 0);
    checkOutput("rst_sel_id", int'(selId), 0);
    for (int c = 0; c <= N; c++) begin
      checkOutput("lit_loading_high", int'(loading), 1);
      if (c < N) checkOutput("lit_rd_id", int'(rdId), c);
      @(negedge clk);
    end
    checkOutput("lit_loading_low", int'(loading), 0);
    checkRow("lit_row0", getRow(0), padBytes(">>> [00]  SONG_0", RC));
    checkRow("lit_row4", getRow(4), padBytes("    [04]  SONG_4", RC));

    checkOutput("n3_loading", int'(loading3), 0);
    checkOutput("n3_cursor", int'(cursor3), 0);
    checkOutput("n3_top", int'(top3), 0);
    checkOutput("n3_sel", int'(selValid3) + int'(selAuto3) + int'(selId3), 0);
    checkRow("n3_row0", getRow3(0), padBytes(">>> [00]  SONG_0", RC));
    checkRow("n3_row2", getRow3(2), padBytes("    [02]  SONG_2", RC));
    checkRow("n3_row3", getRow3(3), padBytes("", RC));
    checkRow("n3_row4", getRow3(4), padBytes("", RC));

    pressKey(K_DOWN, 5);
    checkOutput("lit_down5_cursor", int'(cursor), 5);
    checkOutput("lit_down5_top", int'(top), 1);
    pressKey(K_UP, 6);
    checkOutput("lit_up6_cursor", int'(cursor), 15);
    checkOutput("lit_up6_top", int'(top), 11);
    pressKey(K_DOWN, 1);
    checkOutput("lit_wrap0_cursor", int'(cursor), 0);
    checkOutput("lit_wrap0_top", int'(top), 0);

    applyStimulus(K_DOWN, 1);
    checkOutput("lit_hold_press", int'(cursor), 1);
    for (int k = 1; k <= 74; k++) begin
      applyStimulus(K_DOWN, 1);
      if (k == 49 || k == 50 || k == 59 || k == 60 || k == 69 || k == 70 || k == 74)
        checkOutput($sformatf("lit_hold_k%0d", k), int'(cursor),
                    (k < 50) ? 1 : (k < 60) ? 2 : (k < 70) ? 3 : 4);
    end
    applyStimulus(K_NONE, 1);

    pressKey(K_DOWN, 3);
    checkOutput("lit_at7_cursor", int'(cursor), 7);
    checkOutput("lit_at7_top", int'(top), 3);
    applyStimulus(K_RIGHT, 1);
    checkOutput("lit_right_valid", int'(selValid), 1);
    checkOutput("lit_right_id", int'(selId), 7);
    checkOutput("lit_right_auto", int'(selAuto), 0);
    applyStimulus(K_RIGHT, 3);
    checkOutput("lit_right_norepeat", int'(selValid), 0);
    applyStimulus(K_NONE, 1);

    pressKey(K_UP, 7);
    applyStimulus(K_LEFT, 1);
    checkOutput("lit_left0_valid", int'(selValid), 0);
    checkOutput("lit_left0_id_held", int'(selId), 7);
    applyStimulus(K_NONE, 1);
    pressKey(K_DOWN, 3);
    applyStimulus(K_LEFT, 1);
    checkOutput("lit_left3_valid", int'(selValid), 1);
    checkOutput("lit_left3_id", int'(selId), 3);
    checkOutput("lit_left3_auto", int'(selAuto), 1);
    applyStimulus(K_NONE, 1);

    applyStimulus(K_UP | K_DOWN, 4);
    checkOutput("lit_updown_cursor", int'(cursor), 3);
    applyStimulus(K_NONE, 1);

    pressKey(K_DOWN, 5);
    applyStimulus(K_DOWN, 6);
    checkOutput("lit_hold9_cursor", int'(cursor), 9);
    rst = 1'b1;
    applyStimulus(K_DOWN, 1);
    rst = 1'b0;
    checkOutput("lit_midhold_cursor", int'(cursor), 0);
    checkOutput("lit_midhold_top", int'(top), 0);
    checkOutput("lit_midhold_loading", int'(loading), 1);
    checkOutput("lit_midhold_rd_id", int'(rdId), 0);
    cyc = 0;
    while (loading && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("lit_reload_cycles", cyc, 17);
    applyStimulus(K_DOWN, 5);
    checkOutput("lit_held_through_load", int'(cursor), 0);
    applyStimulus(K_NONE, 2);
    pressKey(K_DOWN, 1);
    checkOutput("lit_after_reload", int'(cursor), 1);

    done = 1'b1;
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
